// File: rtl/level2pulse.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : level2pulse
// Purpose  : Converts a level input into one-cycle start/stop pulses on
//            debounced rising/falling edges. A level change is accepted only
//            after FILTER_CYCLES consecutive identical samples. The number of
//            cycles the filtered level spent high is reported with each stop.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   FILTER_CYCLES : consecutive stable samples needed to accept a change (>=1)
//   LEN_W         : width of the high-duration counter hi_len
// Ports
//   clk        in   1      clock, all logic on rising edge
//   rst        in   1      synchronous reset, active-high
//   level_in   in   1      raw level input
//   start      out  1      one-cycle pulse, filtered level went 0->1
//   stop       out  1      one-cycle pulse, filtered level went 1->0
//   level_f    out  1      filtered (debounced) level
//   hi_len     out  LEN_W  cycles level_f was high, updated with stop
//   hi_len_vld out  1      one-cycle pulse, coincident with stop
// Build option
//   SYNC2_EN : when defined, level_in passes through a 2-flop synchroniser
//              (reset to 0) before the filter; all latencies grow by 2 cycles
//              and level_in may be asynchronous to clk.
// ============================================================================
module level2pulse #(
  parameter int FILTER_CYCLES = 3,
  parameter int LEN_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             level_in,
  output logic             start,
  output logic             stop,
  output logic             level_f,
  output logic [LEN_W-1:0] hi_len,
  output logic             hi_len_vld
);

  // qcnt must be able to hold FILTER_CYCLES itself
  localparam int             QW        = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES + 1) : 1;
  localparam logic [QW-1:0]  C_QMAX    = QW'(FILTER_CYCLES);
  localparam logic [LEN_W-1:0] C_RUN_MAX = '1;

  typedef enum logic [1:0] {
    LOW_STABLE  = 2'd0,
    QUAL_HIGH   = 2'd1,
    HIGH_STABLE = 2'd2,
    QUAL_LOW    = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Input sample
  // --------------------------------------------------------------------------
  logic sample;

`ifdef SYNC2_EN
  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= level_in;
      sync2_q <= sync1_q;
    end
  end

  assign sample = sync2_q;
`else
  assign sample = level_in;
`endif

  // --------------------------------------------------------------------------
  // Filter FSM
  // --------------------------------------------------------------------------
  state_t           state_q,      state_d;
  logic [QW-1:0]    qcnt_q,       qcnt_d;
  logic [LEN_W-1:0] run_q,        run_d;
  logic             level_f_q,    level_f_d;
  logic             start_q,      start_d;
  logic             stop_q,       stop_d;
  logic [LEN_W-1:0] hi_len_q,     hi_len_d;
  logic             hi_len_vld_q, hi_len_vld_d;

  logic [QW-1:0]    qcnt_inc;
  logic [LEN_W-1:0] run_inc;

  assign qcnt_inc = qcnt_q + QW'(1);
  assign run_inc  = (run_q == C_RUN_MAX) ? run_q : run_q + LEN_W'(1);

  always_comb begin
    state_d      = state_q;
    qcnt_d       = qcnt_q;
    run_d        = run_q;
    level_f_d    = level_f_q;
    start_d      = 1'b0;
    stop_d       = 1'b0;
    hi_len_d     = hi_len_q;
    hi_len_vld_d = 1'b0;

    case (state_q)
      LOW_STABLE: begin
        if (sample) begin
          if (FILTER_CYCLES == 1) begin
            state_d   = HIGH_STABLE;
            level_f_d = 1'b1;
            start_d   = 1'b1;
            run_d     = LEN_W'(1);
          end else begin
            state_d = QUAL_HIGH;
            qcnt_d  = QW'(1);
          end
        end
      end

      QUAL_HIGH: begin
        if (!sample) begin
          state_d = LOW_STABLE;
          qcnt_d  = '0;
        end else if (qcnt_inc == C_QMAX) begin
          state_d   = HIGH_STABLE;
          qcnt_d    = '0;
          level_f_d = 1'b1;
          start_d   = 1'b1;
          run_d     = LEN_W'(1);
        end else begin
          qcnt_d = qcnt_inc;
        end
      end

      HIGH_STABLE: begin
        if (!sample && (FILTER_CYCLES == 1)) begin
          // The fall edge itself is not a high cycle, so report run_q as-is.
          state_d      = LOW_STABLE;
          level_f_d    = 1'b0;
          stop_d       = 1'b1;
          hi_len_vld_d = 1'b1;
          hi_len_d     = run_q;
          run_d        = '0;
        end else begin
          run_d = run_inc;
          if (!sample) begin
            state_d = QUAL_LOW;
            qcnt_d  = QW'(1);
          end
        end
      end

      QUAL_LOW: begin
        if (sample) begin
          // Dip absorbed; the high duration includes the dip cycles.
          state_d = HIGH_STABLE;
          qcnt_d  = '0;
          run_d   = run_inc;
        end else if (qcnt_inc == C_QMAX) begin
          state_d      = LOW_STABLE;
          qcnt_d       = '0;
          level_f_d    = 1'b0;
          stop_d       = 1'b1;
          hi_len_vld_d = 1'b1;
          hi_len_d     = run_q;
          run_d        = '0;
        end else begin
          qcnt_d = qcnt_inc;
          run_d  = run_inc;
        end
      end

      default: begin
        state_d = LOW_STABLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOW_STABLE;
      qcnt_q       <= '0;
      run_q        <= '0;
      level_f_q    <= 1'b0;
      start_q      <= 1'b0;
      stop_q       <= 1'b0;
      hi_len_q     <= '0;
      hi_len_vld_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      qcnt_q       <= qcnt_d;
      run_q        <= run_d;
      level_f_q    <= level_f_d;
      start_q      <= start_d;
      stop_q       <= stop_d;
      hi_len_q     <= hi_len_d;
      hi_len_vld_q <= hi_len_vld_d;
    end
  end

  assign start      = start_q;
  assign stop       = stop_q;
  assign level_f    = level_f_q;
  assign hi_len     = hi_len_q;
  assign hi_len_vld = hi_len_vld_q;

endmodule
`default_nettype wire
